// File: rtl/ysyx_25020047_lsu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_lsu_ctrl_pkg
// Shared definitions for the LSU controller slice:
//   - lsu_state_e      : controller FSM state encoding (also used on the
//                        debug state output)
//   - SZ_BYTE/SZ_WORD  : ex_size encodings
//   - TIMEOUT_CYC_DEF  : default abort bound for the REQ/RESP wait states
//   - CNT_W            : width of the wait-cycle counter (covers 1..65535)
// ---------------------------------------------------------------------------
package ysyx_25020047_lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int          CNT_W           = 16;

endpackage

// File: rtl/ysyx_25020047_lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_lsu_ctrl_if
// Bundles the EXU-side op channel and the memory request/response channels
// of the LSU controller.
//
// Handshake rules (all channels):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   The source holds valid and its payload stable until the transfer; the
//   sink may raise or lower ready freely. lsu_done is a one-cycle pulse with
//   no back-pressure; lsu_err and lsu_rdata are meaningful while it is high.
//
// Modports:
//   slave  - the LSU controller view (accepts EXU ops, masters the memory bus)
//   master - the environment view (issues EXU ops, serves the memory bus)
// Signals:
//   ex_valid/ex_read/ex_write/ex_size/ex_addr/ex_wdata, ex_ready
//   lsu_done/lsu_rdata/lsu_err
//   mem_req_valid/mem_req_ready/mem_addr/mem_wen/mem_wdata/mem_wstrb
//   mem_rsp_valid/mem_rsp_ready/mem_rsp_data/mem_rsp_err
// ---------------------------------------------------------------------------
interface ysyx_25020047_lsu_ctrl_if;

    logic        ex_valid;
    logic        ex_read;
    logic        ex_write;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_ready;

    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    modport slave (
        input  ex_valid, ex_read, ex_write, ex_size, ex_addr, ex_wdata,
        output ex_ready,
        output lsu_done, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output mem_rsp_ready
    );

    modport master (
        output ex_valid, ex_read, ex_write, ex_size, ex_addr, ex_wdata,
        input  ex_ready,
        input  lsu_done, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  mem_rsp_ready
    );

endinterface

// File: rtl/ysyx_25020047_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_lsu_align
// Purely combinational lane alignment for the LSU.
//   Store path: builds the byte strobe and lane-replicated write data.
//     st_wen_i, st_size_i, st_addr_lo_i, st_wdata_i -> st_wstrb_o, st_wdata_o
//     (loads produce strobe 0 and data 0)
//   Load path: extracts and zero-extends the addressed byte, or passes a
//   whole word through.
//     ld_size_i, ld_addr_lo_i, ld_data_i -> ld_data_o
// Any size other than SZ_WORD is handled as a byte access.
// ---------------------------------------------------------------------------
module ysyx_25020047_lsu_align
    import ysyx_25020047_lsu_ctrl_pkg::*;
(
    input  logic        st_wen_i,
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] st_wdata_o,

    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);

    always_comb begin
        st_wstrb_o = 4'h0;
        st_wdata_o = 32'h0;
        if (st_wen_i) begin
            if (st_size_i == SZ_WORD) begin
                st_wstrb_o = 4'hF;
                st_wdata_o = st_wdata_i;
            end else begin
                st_wstrb_o = 4'b0001 << st_addr_lo_i;
                // Replicating the byte lets the memory pick any lane via wstrb.
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
        end
    end

    always_comb begin
        ld_data_o = 32'h0;
        if (ld_size_i == SZ_WORD) begin
            ld_data_o = ld_data_i;
        end else begin
            ld_data_o = {24'h0, ld_data_i[{ld_addr_lo_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/ysyx_25020047_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_lsu_ctrl
// Load/store unit controller: accepts one EXU memory op at a time, issues a
// single request on the memory bus, waits for the response and reports a
// one-cycle completion pulse with read data and error status.
//
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous, active-high reset
//   bus     - ysyx_25020047_lsu_ctrl_if.slave (EXU op, completion, memory
//             request and response channels)
//   state_o - current FSM state (debug observation)
// Parameters:
//   TIMEOUT_CYC - max cycles waited in REQ or RESP before aborting with an
//                 error (1..65535)
// Configuration macro:
//   YSYX_25020047_MISALIGN_CHK_EN - when defined, misaligned word accesses
//   complete immediately with an error; otherwise they are issued with the
//   low address bits forced to zero.
//
// All outputs are registered. Latency with an always-ready memory is
// accept -> REQ -> RESP -> DONE, i.e. lsu_done three cycles after accept.
// ---------------------------------------------------------------------------
module ysyx_25020047_lsu_ctrl
    import ysyx_25020047_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_25020047_lsu_ctrl_if.slave   bus,
    output lsu_state_e                state_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ex_ready_q;
    logic             lsu_done_q;
    logic             lsu_err_q;
    logic [31:0]      lsu_rdata_q;
    logic             mem_req_valid_q;
    logic [31:0]      mem_addr_q;
    logic             mem_wen_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_wstrb_q;
    logic             mem_rsp_ready_q;
    logic [1:0]       size_q;
    logic [1:0]       addr_lo_q;

    logic             op_legal;
    logic             is_word;
    logic             chk_fail;
    logic [31:0]      issue_addr;
    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;

    // Exactly one direction must be requested.
    assign op_legal = bus.ex_read ^ bus.ex_write;
    assign is_word  = (bus.ex_size == SZ_WORD);

`ifdef YSYX_25020047_MISALIGN_CHK_EN
    assign chk_fail   = is_word && (bus.ex_addr[1:0] != 2'b00);
    assign issue_addr = bus.ex_addr;
`else
    assign chk_fail   = 1'b0;
    assign issue_addr = is_word ? {bus.ex_addr[31:2], 2'b00} : bus.ex_addr;
`endif

    // Store lanes are computed from the live EXU op (captured on accept);
    // load extraction uses the size/offset latched with the op.
    ysyx_25020047_lsu_align u_align (
        .st_wen_i     (bus.ex_write),
        .st_size_i    (bus.ex_size),
        .st_addr_lo_i (bus.ex_addr[1:0]),
        .st_wdata_i   (bus.ex_wdata),
        .st_wstrb_o   (st_wstrb),
        .st_wdata_o   (st_wdata),
        .ld_size_i    (size_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_data_i    (bus.mem_rsp_data),
        .ld_data_o    (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            ex_ready_q      <= 1'b1;
            lsu_done_q      <= 1'b0;
            lsu_err_q       <= 1'b0;
            lsu_rdata_q     <= 32'h0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= 32'h0;
            mem_wstrb_q     <= 4'h0;
            mem_rsp_ready_q <= 1'b0;
            size_q          <= SZ_BYTE;
            addr_lo_q       <= 2'b00;
        end else begin
            lsu_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.ex_valid) begin
                        ex_ready_q <= 1'b0;
                        if (op_legal && !chk_fail) begin
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= issue_addr;
                            mem_wen_q       <= bus.ex_write;
                            mem_wdata_q     <= st_wdata;
                            mem_wstrb_q     <= st_wstrb;
                            size_q          <= bus.ex_size;
                            addr_lo_q       <= bus.ex_addr[1:0];
                            cnt_q           <= '0;
                            state_q         <= ST_REQ;
                        end else begin
                            // Rejected op: report the error without touching the bus.
                            lsu_done_q  <= 1'b1;
                            lsu_err_q   <= 1'b1;
                            lsu_rdata_q <= 32'h0;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_rsp_ready_q <= 1'b1;
                        cnt_q           <= '0;
                        state_q         <= ST_RESP;
                    end else if (cnt_q == TMO_LAST) begin
                        mem_req_valid_q <= 1'b0;
                        lsu_done_q      <= 1'b1;
                        lsu_err_q       <= 1'b1;
                        lsu_rdata_q     <= 32'h0;
                        state_q         <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_rsp_valid) begin
                        mem_rsp_ready_q <= 1'b0;
                        lsu_done_q      <= 1'b1;
                        lsu_err_q       <= bus.mem_rsp_err;
                        lsu_rdata_q     <= mem_wen_q ? 32'h0 : ld_data;
                        state_q         <= ST_DONE;
                    end else if (cnt_q == TMO_LAST) begin
                        // Abort; any later response arrives in IDLE and is ignored.
                        mem_rsp_ready_q <= 1'b0;
                        lsu_done_q      <= 1'b1;
                        lsu_err_q       <= 1'b1;
                        lsu_rdata_q     <= 32'h0;
                        state_q         <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    lsu_err_q  <= 1'b0;
                    ex_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ex_ready      = ex_ready_q;
    assign bus.lsu_done      = lsu_done_q;
    assign bus.lsu_err       = lsu_err_q;
    assign bus.lsu_rdata     = lsu_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
    assign bus.mem_rsp_ready = mem_rsp_ready_q;
    assign state_o           = state_q;

endmodule

// File: doc/ysyx_25020047_lsu_ctrl.md
YSYX_25020047_LSU_CTRL -- requirements
Module: ysyx_25020047_lsu_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum cycles spent waiting in REQ or RESP before abort; legal range 1..65535.
REQ-002 The block SHALL have ports `clock`  in  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have ports `reset`  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports `ex_valid` in 1 (EXU op offered), `ex_read` in 1, `ex_write` in 1, `ex_size` in 2 (00 byte, 10 word), `ex_addr` in 32 (EXU result), `ex_wdata` in 32 (store data).
REQ-005 The block SHALL have ports `ex_ready` out 1 (op accepted this cycle), `lsu_done` out 1 (one-cycle completion pulse), `lsu_rdata` out 32, `lsu_err` out 1 (valid with `lsu_done`).
REQ-006 The block SHALL have ports `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_addr` out 32, `mem_wen` out 1, `mem_wdata` out 32, `mem_wstrb` out 4.
REQ-007 The block SHALL have ports `mem_rsp_valid` in 1, `mem_rsp_ready` out 1, `mem_rsp_data` in 32, `mem_rsp_err` in 1.

Function
REQ-008 The FSM SHALL have states IDLE, REQ, RESP and DONE, and SHALL be in IDLE after reset.
REQ-009 In IDLE, `ex_ready` SHALL be 1; `ex_valid` with exactly one of `ex_read` or `ex_write` set SHALL latch addr, size, wdata and direction, then go to REQ.
REQ-010 `ex_valid` with both or neither of `ex_read`/`ex_write` set SHALL go to DONE with `lsu_err`=1 and issue no bus request.
REQ-011 In REQ, `mem_req_valid` SHALL be 1 and addr, wen, wdata and wstrb SHALL be held stable; on `mem_req_valid && mem_req_ready` the FSM SHALL go to RESP.
REQ-012 For byte stores, `mem_wstrb` SHALL be 1<<addr[1:0] and `mem_wdata` SHALL replicate byte[7:0] into all four lanes; for word stores, `mem_wstrb` SHALL be 4'hF and `mem_wdata` SHALL equal `ex_wdata`.
REQ-013 In RESP, `mem_rsp_ready` SHALL be 1; on `mem_rsp_valid` the FSM SHALL capture the response and go to DONE.
REQ-014 Byte loads SHALL zero-extend the lane selected by addr[1:0]; word loads SHALL pass `mem_rsp_data` through unchanged; stores SHALL return 0.
REQ-015 DONE SHALL last exactly one cycle with `lsu_done`=1, `lsu_err` equal to the captured `mem_rsp_err`, then return to IDLE; `lsu_rdata` SHALL hold its value until the next DONE.
REQ-016 A cycle counter SHALL clear on entry to REQ and on entry to RESP; reaching TIMEOUT_CYC SHALL force DONE with `lsu_err`=1, and a stale `mem_rsp_valid` arriving later in IDLE SHALL be ignored.
REQ-017 Minimum latency from accept to `lsu_done` SHALL be 3 cycles, achieved with `mem_req_ready` and `mem_rsp_valid` both held at 1.
REQ-018 `ex_ready` SHALL be 0 in REQ, RESP and DONE, so there is no back-to-back accept in DONE.

Reset
REQ-019 Reset SHALL immediately force IDLE, zero all outputs except `ex_ready` (which SHALL be 1), and clear the counter and latches, including when asserted mid-transaction; no response is owed after reset.

Configuration
REQ-020 With `YSYX_25020047_MISALIGN_CHK_EN` defined, a word access with addr[1:0]!=0 SHALL go to DONE with `lsu_err`=1 and no bus request.
REQ-021 Without `YSYX_25020047_MISALIGN_CHK_EN`, such an access SHALL be issued with addr[1:0] forced to 0.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the size encodings (SZ_BYTE=2'b00, SZ_WORD=2'b10) and the default TIMEOUT_CYC.
REQ-023 Lane alignment (wstrb/wdata generation and load extraction) SHALL live in one combinational sub-module, `ysyx_25020047_lsu_align`.

Verification
REQ-024 Word load: addr 0x80000004, rsp_data 0xDEADBEEF, ready/valid held at 1 -> `lsu_done` on cycle 3, `lsu_rdata`=0xDEADBEEF, `lsu_err`=0.
REQ-025 Byte store: addr 0x80000003, wdata 0x000000A5 -> `mem_wstrb`=4'b1000, `mem_wdata`=0xA5A5A5A5, `mem_wen`=1.
REQ-026 Byte load: addr 0x80000002, rsp 0x11223344 -> `lsu_rdata`=0x00000022; with `mem_req_ready` low for 5 cycles, addr, wen, wdata and wstrb stay stable throughout.
REQ-027 Timeout: TIMEOUT_CYC=8 and `mem_rsp_valid` never asserted -> `lsu_done` with `lsu_err`=1 at 8 cycles after RESP entry, then IDLE.
REQ-028 Reset: assert `reset` in RESP -> IDLE the same cycle, no `lsu_done` pulse, `ex_ready`=1.
REQ-029 Illegal op: `ex_read`=`ex_write`=1 -> `lsu_err`=1 and `mem_req_valid` never asserted.
REQ-030 Misaligned word: addr 0x...2 with `YSYX_25020047_MISALIGN_CHK_EN` defined -> `lsu_err`=1 and `mem_req_valid` never asserted.
